// File: rtl/tiled_matmul_control_unit.sv
// Sequencer for one tiled matmul C[HxN] = A[HxK] * W[KxN] on a MUL_SIZE x MUL_SIZE array.
// Latency: row 0 issues with the first swap; accumulator writes trail activations by ACC_LAT.
// Backpressure: weight loads wait on weight_fifo_valid_i, drain reads advance only on out_ready_i.
// Ports: clk_i/rst_i; start_i with H/K/N dims and ub_base_i; weight FIFO valid/pop; activation
// read address/valid; accumulator write strobe/addr/add/mask; drain read/addr with out_ready_i;
// status busy_o, stall_compute_o, cfg_err_o, done_o.
module tiled_matmul_control_unit #(
    parameter int MUL_SIZE   = 32,
    parameter int DIM_W      = 12,
    parameter int UB_ADDR_W  = 12,
    parameter int ACC_ADDR_W = 7,
    parameter int ACC_LAT    = 2 * MUL_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ACC_ADDR_W:0]   H_DIM_i,
    input  logic [DIM_W-1:0]      K_DIM_i,
    input  logic [DIM_W-1:0]      N_DIM_i,
    input  logic [UB_ADDR_W-1:0]  ub_base_i,
    input  logic                  weight_fifo_valid_i,
    input  logic                  out_ready_i,
    output logic                  load_weights_o,
    output logic                  swap_weights_o,
    output logic [UB_ADDR_W-1:0]  ub_addr_rd_o,
    output logic                  act_valid_o,
    output logic                  stall_compute_o,
    output logic                  acc_wr_o,
    output logic [ACC_ADDR_W-1:0] acc_addr_wr_o,
    output logic                  acc_add_o,
    output logic [MUL_SIZE-1:0]   acc_col_mask_o,
    output logic                  acc_rd_o,
    output logic [ACC_ADDR_W-1:0] acc_addr_rd_o,
    output logic                  busy_o,
    output logic                  cfg_err_o,
    output logic                  done_o
);
    localparam int LG   = $clog2(MUL_SIZE);
    localparam int FL_W = $clog2(ACC_LAT + 1);
    localparam int TT_W = 2 * DIM_W;
    localparam logic [ACC_ADDR_W:0] H_MAX = {1'b1, {ACC_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_PRELOAD, S_COMPUTE, S_WAIT_W, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    typedef struct packed {
        logic                  vld;
        logic [ACC_ADDR_W-1:0] addr;
        logic                  add;
        logic [MUL_SIZE-1:0]   mask;
    } wr_t;

    state_t                state_q, state_d;
    logic [ACC_ADDR_W:0]   h_q;
    logic [DIM_W-1:0]      kt_tot_q, nt_tot_q;
    logic [MUL_SIZE-1:0]   last_mask_q;
    logic [UB_ADDR_W-1:0]  ub_base_q;
    logic [ACC_ADDR_W-1:0] r_q, r_d, d_q, d_d;
    logic [DIM_W-1:0]      kt_q, kt_d, nt_q, nt_d;
    logic [UB_ADDR_W-1:0]  kt_off_q, kt_off_d;   // running kt*H
    logic [FL_W-1:0]       fl_q, fl_d;
    logic [LG-1:0]         row_q, row_d;
    logic [TT_W-1:0]       tiles_q, tiles_d;
    logic                  shadow_full_q, shadow_full_d;
    logic                  cfg_err_q;
    wr_t                   pipe_q [ACC_LAT];
    wr_t                   wr_in;

    // Config decode: tile counts by shift, last-N-tile column mask.
    logic [DIM_W:0]      k_round, n_round;
    logic [DIM_W-1:0]    kt_calc, nt_calc;
    logic [LG-1:0]       n_rem;
    logic [MUL_SIZE-1:0] mask_calc;
    logic                cfg_ok, start_ok;

    always_comb begin
        k_round   = {1'b0, K_DIM_i} + (DIM_W+1)'(MUL_SIZE - 1);
        n_round   = {1'b0, N_DIM_i} + (DIM_W+1)'(MUL_SIZE - 1);
        kt_calc   = DIM_W'(k_round >> LG);
        nt_calc   = DIM_W'(n_round >> LG);
        n_rem     = N_DIM_i[LG-1:0];
        mask_calc = (n_rem == '0) ? '1 : ((MUL_SIZE'(1) << n_rem) - MUL_SIZE'(1));
        cfg_ok    = (H_DIM_i != '0) && (K_DIM_i != '0) && (N_DIM_i != '0) && (H_DIM_i <= H_MAX);
        start_ok  = (state_q == S_IDLE) && start_i && cfg_ok;
    end

    logic            last_row, last_kt, last_nt, last_d;
    logic [TT_W-1:0] tiles_total;

    assign last_row    = ({1'b0, r_q} == h_q - (ACC_ADDR_W+1)'(1));
    assign last_d      = ({1'b0, d_q} == h_q - (ACC_ADDR_W+1)'(1));
    assign last_kt     = (kt_q == kt_tot_q - DIM_W'(1));
    assign last_nt     = (nt_q == nt_tot_q - DIM_W'(1));
    assign tiles_total = TT_W'(kt_tot_q) * TT_W'(nt_tot_q);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:              if (start_ok) state_d = S_PRELOAD;
            S_PRELOAD, S_WAIT_W: if (shadow_full_q) state_d = S_COMPUTE;
            S_COMPUTE: begin
                // With H=1 the swap shares the last-row cycle; the shadow
                // being swapped out does not count as the next tile.
                if (last_row) begin
                    if (last_kt)                             state_d = S_FLUSH;
                    else if (shadow_full_q && !swap_weights_o) state_d = S_COMPUTE;
                    else                                     state_d = S_WAIT_W;
                end
            end
            S_FLUSH:  if (fl_q == FL_W'(ACC_LAT - 1)) state_d = S_DRAIN;
            S_DRAIN: begin
                if (acc_rd_o && last_d) begin
                    if (last_nt)            state_d = S_DONE;
                    else if (shadow_full_q) state_d = S_COMPUTE;
                    else                    state_d = S_WAIT_W;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o          = (state_q != S_IDLE);
        act_valid_o     = (state_q == S_COMPUTE);
        swap_weights_o  = act_valid_o && (r_q == '0);   // row 0 issues with its swap
        stall_compute_o = (state_q == S_PRELOAD) || (state_q == S_WAIT_W);
        acc_rd_o        = (state_q == S_DRAIN) && out_ready_i;
        acc_addr_rd_o   = (state_q == S_DRAIN) ? d_q : '0;
        done_o          = (state_q == S_DONE);
        load_weights_o  = busy_o && !shadow_full_q && (tiles_q < tiles_total) && weight_fifo_valid_i;
        ub_addr_rd_o    = act_valid_o ? (ub_base_q + kt_off_q + UB_ADDR_W'(r_q)) : '0;
        cfg_err_o       = cfg_err_q;
    end

    // Counters and weight loader next state
    always_comb begin
        r_d           = r_q;
        d_d           = d_q;
        kt_d          = kt_q;
        nt_d          = nt_q;
        kt_off_d      = kt_off_q;
        fl_d          = '0;
        row_d         = row_q;
        tiles_d       = tiles_q;
        shadow_full_d = shadow_full_q;

        if (start_ok) begin
            r_d      = '0;
            d_d      = '0;
            kt_d     = '0;
            nt_d     = '0;
            kt_off_d = '0;
        end

        case (state_q)
            S_COMPUTE: begin
                if (last_row) begin
                    r_d = '0;
                    if (!last_kt) begin
                        kt_d     = kt_q + DIM_W'(1);
                        kt_off_d = kt_off_q + UB_ADDR_W'(h_q);
                    end
                end else begin
                    r_d = r_q + ACC_ADDR_W'(1);
                end
            end
            S_FLUSH: fl_d = fl_q + FL_W'(1);
            S_DRAIN: begin
                if (acc_rd_o) begin
                    if (last_d) begin
                        d_d = '0;
                        if (!last_nt) begin
                            nt_d     = nt_q + DIM_W'(1);
                            kt_d     = '0;
                            kt_off_d = '0;
                        end
                    end else begin
                        d_d = d_q + ACC_ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Loader runs beside the compute FSM; set and clear of shadow_full
        // never coincide because a load needs the shadow empty.
        if (load_weights_o) begin
            if (row_q == LG'(MUL_SIZE - 1)) begin
                row_d         = '0;
                shadow_full_d = 1'b1;
                tiles_d       = tiles_q + TT_W'(1);
            end else begin
                row_d = row_q + LG'(1);
            end
        end
        if (swap_weights_o) shadow_full_d = 1'b0;
        if (state_q == S_IDLE) begin
            row_d         = '0;
            tiles_d       = '0;
            shadow_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q           <= '0;
            kt_tot_q      <= '0;
            nt_tot_q      <= '0;
            last_mask_q   <= '0;
            ub_base_q     <= '0;
            r_q           <= '0;
            d_q           <= '0;
            kt_q          <= '0;
            nt_q          <= '0;
            kt_off_q      <= '0;
            fl_q          <= '0;
            row_q         <= '0;
            tiles_q       <= '0;
            shadow_full_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                h_q         <= H_DIM_i;
                kt_tot_q    <= kt_calc;
                nt_tot_q    <= nt_calc;
                last_mask_q <= mask_calc;
                ub_base_q   <= ub_base_i;
            end
            r_q           <= r_d;
            d_q           <= d_d;
            kt_q          <= kt_d;
            nt_q          <= nt_d;
            kt_off_q      <= kt_off_d;
            fl_q          <= fl_d;
            row_q         <= row_d;
            tiles_q       <= tiles_d;
            shadow_full_q <= shadow_full_d;
            cfg_err_q     <= (state_q == S_IDLE) && start_i && !cfg_ok;
        end
    end

    // Write descriptor entering the latency-matching pipe; zero when idle.
    always_comb begin
        wr_in      = '0;
        wr_in.vld  = act_valid_o;
        if (act_valid_o) begin
            wr_in.addr = r_q;
            wr_in.add  = (kt_q != '0);
            wr_in.mask = last_nt ? last_mask_q : '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ACC_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= wr_in;
            for (int i = 1; i < ACC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign acc_wr_o       = pipe_q[ACC_LAT-1].vld;
    assign acc_addr_wr_o  = pipe_q[ACC_LAT-1].addr;
    assign acc_add_o      = pipe_q[ACC_LAT-1].add;
    assign acc_col_mask_o = pipe_q[ACC_LAT-1].mask;
endmodule

// File: tb/tb_tiled_matmul_control_unit.sv
// Directed bench for tiled_matmul_control_unit with MUL_SIZE=4, ACC_LAT=8, 16-row accumulator.
// Latency: expectations are hand-derived cycle offsets relative to logged events.
// Backpressure: weight FIFO valid and out_ready are driven per scenario.
module tb_tiled_matmul_control_unit;
    localparam int MS = 4, DW = 12, UW = 12, AW = 4, LAT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   h_dim = '0;
    logic [DW-1:0] k_dim = '0, n_dim = '0;
    logic [UW-1:0] ub_base = '0;
    logic          fifo_vld = 1'b1;
    logic          out_rdy = 1'b1;
    logic          load_w, swap_w, act_vld, stall, acc_wr, acc_add, acc_rd, busy, cfg_err, done;
    logic [UW-1:0] ub_addr;
    logic [AW-1:0] acc_addr_wr, acc_addr_rd;
    logic [MS-1:0] acc_mask;
    logic [33:0]   all_out;

    tiled_matmul_control_unit #(
        .MUL_SIZE(MS), .DIM_W(DW), .UB_ADDR_W(UW), .ACC_ADDR_W(AW), .ACC_LAT(LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .H_DIM_i(h_dim), .K_DIM_i(k_dim),
        .N_DIM_i(n_dim), .ub_base_i(ub_base), .weight_fifo_valid_i(fifo_vld),
        .out_ready_i(out_rdy), .load_weights_o(load_w), .swap_weights_o(swap_w),
        .ub_addr_rd_o(ub_addr), .act_valid_o(act_vld), .stall_compute_o(stall),
        .acc_wr_o(acc_wr), .acc_addr_wr_o(acc_addr_wr), .acc_add_o(acc_add),
        .acc_col_mask_o(acc_mask), .acc_rd_o(acc_rd), .acc_addr_rd_o(acc_addr_rd),
        .busy_o(busy), .cfg_err_o(cfg_err), .done_o(done)
    );

    assign all_out = {load_w, swap_w, ub_addr, act_vld, stall, acc_wr, acc_addr_wr, acc_add,
                      acc_mask, acc_rd, acc_addr_rd, busy, cfg_err, done};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int act_addr_q[$], act_cyc_q[$], wr_addr_q[$], wr_add_q[$], wr_mask_q[$], wr_cyc_q[$];
    int rd_addr_q[$], rd_cyc_q[$], swap_cyc_q[$];
    int done_cnt, err_cnt, stall_cnt, load_cnt, done_cyc;

    always @(negedge clk) begin
        if (!rst) begin
            if (act_vld) begin act_addr_q.push_back(int'(ub_addr)); act_cyc_q.push_back(cyc); end
            if (acc_wr) begin
                wr_addr_q.push_back(int'(acc_addr_wr));
                wr_add_q.push_back(int'(acc_add));
                wr_mask_q.push_back(int'(acc_mask));
                wr_cyc_q.push_back(cyc);
            end
            if (acc_rd) begin rd_addr_q.push_back(int'(acc_addr_rd)); rd_cyc_q.push_back(cyc); end
            if (swap_w) swap_cyc_q.push_back(cyc);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cfg_err) err_cnt++;
            if (stall) stall_cnt++;
            if (load_w) load_cnt++;
        end
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        act_addr_q.delete(); act_cyc_q.delete(); wr_addr_q.delete(); wr_add_q.delete();
        wr_mask_q.delete(); wr_cyc_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
        swap_cyc_q.delete();
        done_cnt = 0; err_cnt = 0; stall_cnt = 0; load_cnt = 0; done_cyc = -1;
    endtask

    task automatic start_job(input int h, input int k, input int n, input int base);
        @(posedge clk); #1;
        h_dim = (AW+1)'(h); k_dim = DW'(k); n_dim = DW'(n); ub_base = UW'(base);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int waited = 0;
        while (done_cnt == 0 && waited < 3000) begin @(negedge clk); waited++; end
        n_chk++;
        if (done_cnt == 0) begin n_fail++; $display("FAIL %s done_timeout got none want done_o", name); end
        repeat (3) @(negedge clk);
        n_chk++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_count got %0d want 1", name, done_cnt); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset outputs got %h want 0", all_out); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_release outputs got %h want 0", all_out); end
    endtask

    task automatic test_single_tile();
        clear_log();
        start_job(3, 4, 4, 100);
        wait_done("single");
        n_chk++;
        if (load_cnt !== 4) begin n_fail++; $display("FAIL single loads got %0d want 4", load_cnt); end
        n_chk++;
        if (swap_cyc_q.size() !== 1 || qget(swap_cyc_q, 0) !== qget(act_cyc_q, 0)) begin
            n_fail++; $display("FAIL single swap got n=%0d cyc=%0d want n=1 cyc=%0d",
                               swap_cyc_q.size(), qget(swap_cyc_q, 0), qget(act_cyc_q, 0));
        end
        n_chk++;
        if (act_addr_q.size() !== 3 || wr_addr_q.size() !== 3 || rd_addr_q.size() !== 3) begin
            n_fail++; $display("FAIL single counts got act=%0d wr=%0d rd=%0d want 3/3/3",
                               act_addr_q.size(), wr_addr_q.size(), rd_addr_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (qget(act_addr_q, i) !== 100 + i || qget(act_cyc_q, i) !== qget(act_cyc_q, 0) + i) begin
                n_fail++; $display("FAIL single act[%0d] got addr=%0d cyc=%0d want addr=%0d", i,
                                   qget(act_addr_q, i), qget(act_cyc_q, i), 100 + i);
            end
            n_chk++;
            if (qget(wr_cyc_q, i) !== qget(act_cyc_q, i) + LAT || qget(wr_addr_q, i) !== i ||
                qget(wr_add_q, i) !== 0 || qget(wr_mask_q, i) !== 15) begin
                n_fail++; $display("FAIL single wr[%0d] got dly=%0d addr=%0d add=%0d mask=%0d want 8/%0d/0/15",
                                   i, qget(wr_cyc_q, i) - qget(act_cyc_q, i), qget(wr_addr_q, i),
                                   qget(wr_add_q, i), qget(wr_mask_q, i), i);
            end
            n_chk++;
            if (qget(rd_addr_q, i) !== i) begin
                n_fail++; $display("FAIL single rd[%0d] got %0d want %0d", i, qget(rd_addr_q, i), i);
            end
        end
        n_chk++;
        if (qget(rd_cyc_q, 0) !== qget(wr_cyc_q, 2) + 1 || done_cyc !== qget(rd_cyc_q, 2) + 1) begin
            n_fail++; $display("FAIL single drain_timing got rd0=%0d done=%0d want %0d/%0d",
                               qget(rd_cyc_q, 0), done_cyc, qget(wr_cyc_q, 2) + 1, qget(rd_cyc_q, 2) + 1);
        end
    endtask

    task automatic test_k_tiles();
        int exp_add[6] = '{0, 0, 1, 1, 1, 1};
        clear_log();
        start_job(2, 12, 4, 20);
        wait_done("ktiles");
        n_chk++;
        if (load_cnt !== 12 || swap_cyc_q.size() !== 3) begin
            n_fail++; $display("FAIL ktiles loads_swaps got %0d/%0d want 12/3", load_cnt, swap_cyc_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (qget(act_addr_q, i) !== 20 + i || qget(wr_add_q, i) !== exp_add[i] ||
                qget(wr_addr_q, i) !== (i % 2)) begin
                n_fail++; $display("FAIL ktiles row[%0d] got ub=%0d add=%0d acc=%0d want %0d/%0d/%0d", i,
                                   qget(act_addr_q, i), qget(wr_add_q, i), qget(wr_addr_q, i),
                                   20 + i, exp_add[i], i % 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        start_job(6, 8, 4, 0);
        wait_done("b2b");
        n_chk++;
        if (act_addr_q.size() !== 12 || qget(act_cyc_q, 11) - qget(act_cyc_q, 0) !== 11) begin
            n_fail++; $display("FAIL b2b bubbles got n=%0d span=%0d want 12/11", act_addr_q.size(),
                               qget(act_cyc_q, 11) - qget(act_cyc_q, 0));
        end
        n_chk++;
        if (qget(swap_cyc_q, 1) !== qget(act_cyc_q, 6) || qget(act_addr_q, 11) !== 11) begin
            n_fail++; $display("FAIL b2b second_tile got swap=%0d row0=%0d addr=%0d want swap=row0 addr=11",
                               qget(swap_cyc_q, 1), qget(act_cyc_q, 6), qget(act_addr_q, 11));
        end
        n_chk++;
        if (stall_cnt !== 5) begin n_fail++; $display("FAIL b2b stall got %0d want 5", stall_cnt); end
    endtask

    task automatic test_n_tiles();
        int exp_mask[4] = '{15, 15, 3, 3};
        clear_log();
        start_job(2, 4, 6, 0);
        wait_done("ntiles");
        n_chk++;
        if (wr_mask_q.size() !== 4 || rd_addr_q.size() !== 4 || load_cnt !== 8) begin
            n_fail++; $display("FAIL ntiles counts got wr=%0d rd=%0d loads=%0d want 4/4/8",
                               wr_mask_q.size(), rd_addr_q.size(), load_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (qget(wr_mask_q, i) !== exp_mask[i] || qget(wr_add_q, i) !== 0 ||
                qget(rd_addr_q, i) !== (i % 2) || qget(act_addr_q, i) !== (i % 2)) begin
                n_fail++; $display("FAIL ntiles row[%0d] got mask=%0d add=%0d rd=%0d ub=%0d want %0d/0/%0d/%0d",
                                   i, qget(wr_mask_q, i), qget(wr_add_q, i), qget(rd_addr_q, i),
                                   qget(act_addr_q, i), exp_mask[i], i % 2, i % 2);
            end
        end
    endtask

    task automatic test_weight_stall();
        int seen = 0, waited = 0;
        clear_log();
        start_job(3, 8, 4, 0);
        while (seen < 4 && waited < 100) begin
            @(negedge clk); waited++;
            if (load_w) seen++;
        end
        @(posedge clk); #1;
        fifo_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1 fifo_vld = 1'b1;
        wait_done("wstall");
        n_chk++;
        if (stall_cnt !== 16) begin n_fail++; $display("FAIL wstall stall got %0d want 16", stall_cnt); end
        n_chk++;
        if (qget(act_cyc_q, 3) - qget(act_cyc_q, 2) !== 12 || qget(swap_cyc_q, 1) !== qget(act_cyc_q, 3)) begin
            n_fail++; $display("FAIL wstall resume got gap=%0d swap=%0d want gap=12 swap=%0d",
                               qget(act_cyc_q, 3) - qget(act_cyc_q, 2), qget(swap_cyc_q, 1), qget(act_cyc_q, 3));
        end
        n_chk++;
        if (act_addr_q.size() !== 6 || qget(act_addr_q, 5) !== 5) begin
            n_fail++; $display("FAIL wstall rows got n=%0d last=%0d want 6/5", act_addr_q.size(), qget(act_addr_q, 5));
        end
    endtask

    task automatic test_drain_backpressure();
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int waited = 0;
        bit seen = 1'b0;
        clear_log();
        out_rdy = 1'b0;
        start_job(3, 4, 4, 0);
        while (!seen && waited < 200) begin
            @(negedge clk); waited++;
            if (acc_wr && acc_addr_wr == AW'(2)) seen = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            out_rdy = pat[i];
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        wait_done("drain");
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (qget(rd_addr_q, i) !== i) begin
                n_fail++; $display("FAIL drain rd[%0d] got %0d want %0d", i, qget(rd_addr_q, i), i);
            end
        end
        n_chk++;
        if (rd_addr_q.size() !== 3 || qget(rd_cyc_q, 1) - qget(rd_cyc_q, 0) !== 3 ||
            qget(rd_cyc_q, 2) - qget(rd_cyc_q, 0) !== 4 || done_cyc - qget(rd_cyc_q, 0) !== 5) begin
            n_fail++; $display("FAIL drain timing got n=%0d d1=%0d d2=%0d dd=%0d want 3/3/4/5", rd_addr_q.size(),
                               qget(rd_cyc_q, 1) - qget(rd_cyc_q, 0), qget(rd_cyc_q, 2) - qget(rd_cyc_q, 0),
                               done_cyc - qget(rd_cyc_q, 0));
        end
    endtask

    task automatic test_cfg_err();
        int hs[3] = '{0, 2, 17};
        int ks[3] = '{4, 0, 4};
        for (int t = 0; t < 3; t++) begin
            clear_log();
            start_job(hs[t], ks[t], 4, 0);
            @(negedge clk);
            n_chk++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL cfgerr[%0d] pulse got err=%b busy=%b want 1/0", t, cfg_err, busy);
            end
            repeat (4) @(negedge clk);
            n_chk++;
            if (err_cnt !== 1 || busy !== 1'b0 || act_addr_q.size() !== 0) begin
                n_fail++; $display("FAIL cfgerr[%0d] after got errs=%0d busy=%b acts=%0d want 1/0/0",
                                   t, err_cnt, busy, act_addr_q.size());
            end
        end
        // Largest legal H fills the accumulator.
        clear_log();
        start_job(16, 4, 4, 0);
        wait_done("hmax");
        n_chk++;
        if (err_cnt !== 0 || rd_addr_q.size() !== 16 || qget(rd_addr_q, 15) !== 15 || qget(act_addr_q, 15) !== 15) begin
            n_fail++; $display("FAIL hmax got errs=%0d rd=%0d last_rd=%0d last_ub=%0d want 0/16/15/15",
                               err_cnt, rd_addr_q.size(), qget(rd_addr_q, 15), qget(act_addr_q, 15));
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        clear_log();
        start_job(6, 8, 4, 0);
        while (!act_vld && waited < 100) begin @(negedge clk); waited++; end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (all_out !== '0) begin n_fail++; $display("FAIL rstmid async got %h want 0", all_out); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        n_chk++;
        if (done_cnt !== 0 || busy !== 1'b0 || all_out !== '0) begin
            n_fail++; $display("FAIL rstmid after got done=%0d busy=%b out=%h want 0/0/0", done_cnt, busy, all_out);
        end
    endtask

    task automatic test_single_row();
        clear_log();
        start_job(1, 8, 4, 7);
        wait_done("h1");
        n_chk++;
        if (swap_cyc_q.size() !== 2 || act_addr_q.size() !== 2 ||
            qget(act_cyc_q, 1) - qget(act_cyc_q, 0) !== 6) begin
            n_fail++; $display("FAIL h1 tiles got swaps=%0d acts=%0d gap=%0d want 2/2/6", swap_cyc_q.size(),
                               act_addr_q.size(), qget(act_cyc_q, 1) - qget(act_cyc_q, 0));
        end
        n_chk++;
        if (qget(act_addr_q, 0) !== 7 || qget(act_addr_q, 1) !== 8 ||
            qget(wr_add_q, 0) !== 0 || qget(wr_add_q, 1) !== 1) begin
            n_fail++; $display("FAIL h1 rows got ub=%0d,%0d add=%0d,%0d want 7,8 0,1", qget(act_addr_q, 0),
                               qget(act_addr_q, 1), qget(wr_add_q, 0), qget(wr_add_q, 1));
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_single_tile();
        test_k_tiles();
        test_back_to_back();
        test_n_tiles();
        test_weight_stall();
        test_drain_backpressure();
        test_cfg_err();
        test_reset_mid();
        test_single_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
